// File: rtl/note_pkg.sv
// note_pkg: shared constants and types for the note field renderer.
//   - 6-bit RRGGBB colour constants and the per-lane colour table
//   - bcd5_t: five packed BCD digits, digit 4 is the most significant
//   - popcount8: counts set bits, used to turn hit pulses into a score increment
package note_pkg;

  localparam logic [5:0] BLACK    = 6'b000000;
  localparam logic [5:0] RED      = 6'b110000;
  localparam logic [5:0] GREEN    = 6'b001100;
  localparam logic [5:0] BLUE     = 6'b000011;
  localparam logic [5:0] YELLOW   = 6'b111100;
  localparam logic [5:0] ORANGE   = 6'b110100;
  localparam logic [5:0] CYAN     = 6'b001111;
  localparam logic [5:0] MAGENTA  = 6'b110011;
  localparam logic [5:0] WHITE    = 6'b111111;
  localparam logic [5:0] HIT_GREY = 6'b101010;

  localparam logic [5:0] LANE_COLOUR [8] = '{GREEN, RED, YELLOW, BLUE, ORANGE, CYAN, MAGENTA, WHITE};

  typedef logic [4:0][3:0] bcd5_t;

  localparam bcd5_t BCD_MAX = 20'h99999;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_score_acc.sv
// bcd_score_acc: five-digit BCD accumulator, saturating at 99999.
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset (score -> 0)
//   clear_i  in  synchronous clear, wins over add_i
//   add_i    in  increment, 0..8 per cycle
//   score_o  out current score, registered
module bcd_score_acc
  import note_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic [3:0] add_i,
  output bcd5_t      score_o
);

  bcd5_t score_q, score_d;

  // Ripple add: add_i enters digit 0, every higher digit receives only the
  // carry. Digit + 8 never exceeds 17, so one conditional -10 per digit suffices.
  always_comb begin
    logic [4:0] sum;
    logic       carry;
    sum     = '0;
    carry   = 1'b0;
    score_d = score_q;
    for (int d = 0; d < 5; d++) begin
      sum = {1'b0, score_q[d]} + ((d == 0) ? {1'b0, add_i} : {4'b0000, carry});
      if (sum >= 5'd10) begin
        score_d[d] = 4'(sum - 5'd10);
        carry      = 1'b1;
      end else begin
        score_d[d] = sum[3:0];
        carry      = 1'b0;
      end
    end
    if (carry) score_d = BCD_MAX;  // carry out of digit 4 means we passed 99999
    if (clear_i) score_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) score_q <= '0;
    else        score_q <= score_d;
  end

  assign score_o = score_q;

endmodule

// File: rtl/note_field_gen.sv
// note_field_gen: falling-note lanes with scroll, spawn, press judging,
// BCD score and a registered 6-bit pixel output.
//   clk, rst_n       clock, asynchronous active-low reset
//   col_i, row_i     current pixel coordinate; valid_i marks the visible area
//   frame_tick_i     one pulse per frame, scrolls the field by SPEED pixels
//   clear_i          synchronous game restart (notes, pending spawns, score)
//   spawn_valid_i/spawn_lane_i/spawn_ready_o  spawn handshake
//   btn_i            debounced lane buttons (level, pressed on rising edge)
//   hit_o, miss_o    one-cycle per-lane judgement pulses
//   score_bcd_o      5-digit BCD score
//   rgb_o            pixel colour, one clock after col_i/row_i/valid_i
module note_field_gen
  import note_pkg::*;
#(
  parameter  int NUM_LANES = 5,
  parameter  int LANE_X0   = 220,
  parameter  int LANE_W    = 35,
  parameter  int LANE_GAP  = 20,
  parameter  int SLOT_H    = 16,
  parameter  int NUM_SLOTS = 30,
  parameter  int HIT_SLOT  = 27,
  parameter  int SPEED     = 2,
  localparam int LW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           col_i,
  input  logic [9:0]           row_i,
  input  logic                 valid_i,
  input  logic                 frame_tick_i,
  input  logic                 clear_i,
  input  logic                 spawn_valid_i,
  input  logic [LW-1:0]        spawn_lane_i,
  output logic                 spawn_ready_o,
  input  logic [NUM_LANES-1:0] btn_i,
  output logic [NUM_LANES-1:0] hit_o,
  output logic [NUM_LANES-1:0] miss_o,
  output logic [19:0]          score_bcd_o,
  output logic [5:0]           rgb_o
);

  localparam int OW  = $clog2(SLOT_H);
  localparam int SIW = 10 - OW;
  localparam logic [9:0] HIT_ROW_TOP = 10'(HIT_SLOT * SLOT_H);
  localparam logic [9:0] HIT_ROW_BOT = 10'((HIT_SLOT + 1) * SLOT_H - 1);

  logic [NUM_SLOTS-1:0] slots_q [NUM_LANES];
  logic [NUM_SLOTS-1:0] slots_d [NUM_LANES];
  logic [NUM_LANES-1:0] pending_q, pending_d;
  logic [NUM_LANES-1:0] btn_prev_q, hit_q, hit_d, miss_q, miss_d;
  logic [NUM_LANES-1:0] note_px, line_px;
  logic [OW-1:0]        offset_q, offset_d;
  logic [5:0]           rgb_q, rgb_d;
  logic                 alive_q;
  logic                 lane_ok, pend_sel, accept, tick, shift;
  logic [OW:0]          off_sum;
  logic                 row_ge_off;
  logic [9:0]           row_rel;
  logic [SIW-1:0]       slot_idx;
  logic [3:0]           score_add;
  bcd5_t                score_q;

  // Ready is held low until the first edge after reset.
  always_comb begin
    lane_ok  = ({1'b0, spawn_lane_i} < (LW + 1)'(NUM_LANES));
    pend_sel = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (spawn_lane_i == LW'(l)) pend_sel = pending_q[l];
    end
  end

  assign spawn_ready_o = alive_q && !clear_i && lane_ok && !pend_sel;
  assign accept        = spawn_valid_i && spawn_ready_o;

  // SLOT_H is a power of two and offset+SPEED < 2*SLOT_H, so dropping the top
  // bit of the sum is exactly "offset -= SLOT_H-SPEED" on a wrap.
  assign off_sum  = {1'b0, offset_q} + (OW + 1)'(SPEED);
  assign tick     = frame_tick_i && !clear_i;
  assign shift    = tick && (off_sum >= (OW + 1)'(SLOT_H));
  assign offset_d = tick ? off_sum[OW-1:0] : offset_q;

  assign row_ge_off = (row_i >= 10'(offset_q));
  assign row_rel    = row_i - 10'(offset_q);
  assign slot_idx   = row_rel[9:OW];

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    localparam logic [10:0] LX_L = 11'(LANE_X0 + gi * (LANE_W + LANE_GAP));
    localparam logic [10:0] LX_R = 11'(LANE_X0 + gi * (LANE_W + LANE_GAP) + LANE_W);

    logic                 press, hit_now, fall, in_lane;
    logic [NUM_SLOTS-1:0] judged;
    logic [2**SIW-1:0]    slot_pad;

    // Judge on pre-shift contents; a hit note is removed before the shift.
    always_comb begin
      press   = btn_i[gi] & ~btn_prev_q[gi];
      hit_now = press & slots_q[gi][HIT_SLOT];
      judged  = slots_q[gi];
      if (hit_now) judged[HIT_SLOT] = 1'b0;
      fall    = shift & judged[NUM_SLOTS-1];
    end

    assign slots_d[gi]   = shift ? {judged[NUM_SLOTS-2:0], pending_q[gi]} : judged;
    assign pending_d[gi] = (pending_q[gi] & ~shift) | (accept && (spawn_lane_i == LW'(gi)));
    assign hit_d[gi]     = hit_now;
    assign miss_d[gi]    = (press & ~hit_now) | fall;  // both causes merge into one pulse

    // Pad the slot vector so every possible slot_idx addresses a real bit.
    always_comb begin
      slot_pad                  = '0;
      slot_pad[NUM_SLOTS-1:0]   = slots_q[gi];
      in_lane = ({1'b0, col_i} >= LX_L) && ({1'b0, col_i} < LX_R);
    end

    assign note_px[gi] = in_lane && row_ge_off && slot_pad[slot_idx];
    assign line_px[gi] = in_lane && ((row_i == HIT_ROW_TOP) || (row_i == HIT_ROW_BOT));
  end

  always_comb begin
    rgb_d = BLACK;
    if (!valid_i) begin
      rgb_d = BLACK;
    end else if ((col_i == 10'd0) || (col_i == 10'd639)) begin
      rgb_d = WHITE;
    end else if (|note_px) begin
      for (int l = NUM_LANES - 1; l >= 0; l--) begin
        if (note_px[l]) rgb_d = LANE_COLOUR[l];
      end
    end else if (|line_px) begin
      rgb_d = HIT_GREY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NUM_LANES; l++) slots_q[l] <= '0;
      pending_q  <= '0;
      offset_q   <= '0;
      btn_prev_q <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      rgb_q      <= '0;
      alive_q    <= 1'b0;
    end else begin
      alive_q    <= 1'b1;
      btn_prev_q <= btn_i;
      rgb_q      <= rgb_d;
      if (clear_i) begin
        for (int l = 0; l < NUM_LANES; l++) slots_q[l] <= '0;
        pending_q <= '0;
        hit_q     <= '0;
        miss_q    <= '0;
      end else begin
        for (int l = 0; l < NUM_LANES; l++) slots_q[l] <= slots_d[l];
        pending_q <= pending_d;
        offset_q  <= offset_d;
        hit_q     <= hit_d;
        miss_q    <= miss_d;
      end
    end
  end

  assign score_add = popcount8(8'(hit_q));

  bcd_score_acc u_score (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .add_i   (score_add),
    .score_o (score_q)
  );

  assign hit_o       = hit_q;
  assign miss_o      = miss_q;
  assign score_bcd_o = score_q;
  assign rgb_o       = rgb_q;

endmodule

// File: tb/tb_note_field_gen.sv
module tb_note_field_gen;

  localparam int NL       = 5;
  localparam int SLOT_PX  = 16;
  localparam int SPD      = 2;
  localparam int HIT_S    = 27;
  localparam int LAST_S   = 29;
  localparam logic [5:0] TB_COL [8] = '{6'h0C, 6'h30, 6'h3C, 6'h03, 6'h34, 6'h0F, 6'h33, 6'h3F};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    col = '0, row = '0;
  logic          valid = 1'b0, frame_tick = 1'b0, clear = 1'b0, spawn_valid = 1'b0;
  logic [2:0]    spawn_lane = '0;
  logic          spawn_ready;
  logic [NL-1:0] btn = '0, hit, miss;
  logic [19:0]   score;
  logic [5:0]    rgb;

  logic          acc_clear = 1'b0;
  logic [3:0]    acc_add = '0;
  logic [19:0]   acc_score;

  always #5 clk = ~clk;

  note_field_gen dut (
    .clk(clk), .rst_n(rst_n), .col_i(col), .row_i(row), .valid_i(valid),
    .frame_tick_i(frame_tick), .clear_i(clear), .spawn_valid_i(spawn_valid),
    .spawn_lane_i(spawn_lane), .spawn_ready_o(spawn_ready), .btn_i(btn),
    .hit_o(hit), .miss_o(miss), .score_bcd_o(score), .rgb_o(rgb)
  );

  bcd_score_acc acc (
    .clk(clk), .rst_n(rst_n), .clear_i(acc_clear), .add_i(acc_add), .score_o(acc_score)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Notes are remembered by the shift count at which they entered slot 0;
  // a note's slot is (shifts so far) - (entry). Scroll is total pixels moved.
  typedef struct { int lane; int entry; } note_t;
  note_t         m_notes[$];
  int            m_total, m_score;
  bit            m_pend [8];
  bit            m_prev [NL];
  bit            m_alive;
  logic [NL-1:0] e_hit, e_miss;
  logic [5:0]    e_rgb;

  function automatic int to_bcd(input int v);
    int r = 0;
    for (int d = 0; d < 5; d++) begin
      r = r | ((v % 10) << (4 * d));
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] model_px(input logic [9:0] c, input logic [9:0] r, input logic v);
    int off = m_total % SLOT_PX;
    int sh  = m_total / SLOT_PX;
    int ci  = int'(c);
    int ri  = int'(r);
    if (!v) return 6'h00;
    if (ci == 0 || ci == 639) return 6'h3F;
    for (int l = 0; l < NL; l++) begin
      int x = 220 + l * 55;
      if (ci >= x && ci < x + 35) begin
        if (ri >= off)
          for (int k = 0; k < m_notes.size(); k++)
            if (m_notes[k].lane == l && sh - m_notes[k].entry == (ri - off) / SLOT_PX) return TB_COL[l];
        if (ri == HIT_S * SLOT_PX || ri == (HIT_S + 1) * SLOT_PX - 1) return 6'h2A;
        return 6'h00;
      end
    end
    return 6'h00;
  endfunction

  task automatic model_reset();
    m_notes.delete();
    m_total = 0; m_score = 0; m_alive = 0;
    for (int l = 0; l < 8; l++) m_pend[l] = 0;
    for (int l = 0; l < NL; l++) m_prev[l] = 0;
    e_hit = '0; e_miss = '0; e_rgb = '0;
  endtask

  // One clock: check ready before the edge, predict, clock, compare outputs.
  task automatic do_cycle();
    logic [NL-1:0] hn, mn;
    logic [5:0]    rgb_n;
    bit            ready_e, found;
    int            sh, sum;
    #1;
    ready_e = m_alive && !clear && (spawn_lane < NL) && !m_pend[spawn_lane];
    check("spawn_ready", 32'(spawn_ready), 32'(ready_e));
    rgb_n = model_px(col, row, valid);
    hn = '0; mn = '0;
    if (clear) begin
      m_notes.delete();
      for (int l = 0; l < 8; l++) m_pend[l] = 0;
      m_score = 0;
    end else begin
      sum = m_score + $countones(e_hit);
      m_score = (sum > 99999) ? 99999 : sum;
      sh = m_total / SLOT_PX;
      for (int l = 0; l < NL; l++) begin
        if (btn[l] && !m_prev[l]) begin
          found = 0;
          for (int k = 0; k < m_notes.size(); k++)
            if (!found && m_notes[k].lane == l && sh - m_notes[k].entry == HIT_S) begin
              m_notes.delete(k);
              found = 1;
            end
          if (found) hn[l] = 1'b1; else mn[l] = 1'b1;
        end
      end
      if (frame_tick) begin
        if ((m_total % SLOT_PX) + SPD >= SLOT_PX) begin
          for (int k = m_notes.size() - 1; k >= 0; k--)
            if (sh - m_notes[k].entry == LAST_S) begin
              mn[m_notes[k].lane] = 1'b1;
              m_notes.delete(k);
            end
          for (int l = 0; l < NL; l++)
            if (m_pend[l]) begin
              m_notes.push_back('{lane: l, entry: sh + 1});
              m_pend[l] = 0;
            end
        end
        m_total += SPD;
      end
      if (spawn_valid && ready_e) m_pend[spawn_lane] = 1;
    end
    for (int l = 0; l < NL; l++) m_prev[l] = btn[l];
    m_alive = 1;
    @(posedge clk); #1;
    e_hit = hn; e_miss = mn; e_rgb = rgb_n;
    check("hit", 32'(hit), 32'(e_hit));
    check("miss", 32'(miss), 32'(e_miss));
    check("score", 32'(score), 32'(to_bcd(m_score)));
    check("rgb", 32'(rgb), 32'(e_rgb));
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) do_cycle();
    frame_tick = 1'b0;
  endtask

  typedef struct { logic [9:0] c; logic [9:0] r; logic v; logic [5:0] exp; } pix_vec_t;
  pix_vec_t pv [14];

  int a_model;

  initial begin
    pv[0]  = '{10'd0,   10'd100, 1'b1, 6'h3F};
    pv[1]  = '{10'd639, 10'd5,   1'b1, 6'h3F};
    pv[2]  = '{10'd0,   10'd100, 1'b0, 6'h00};
    pv[3]  = '{10'd230, 10'd432, 1'b1, 6'h2A};
    pv[4]  = '{10'd230, 10'd447, 1'b1, 6'h2A};
    pv[5]  = '{10'd230, 10'd433, 1'b1, 6'h00};
    pv[6]  = '{10'd254, 10'd432, 1'b1, 6'h2A};
    pv[7]  = '{10'd255, 10'd432, 1'b1, 6'h00};
    pv[8]  = '{10'd219, 10'd447, 1'b1, 6'h00};
    pv[9]  = '{10'd275, 10'd447, 1'b1, 6'h2A};
    pv[10] = '{10'd474, 10'd432, 1'b1, 6'h2A};
    pv[11] = '{10'd475, 10'd432, 1'b1, 6'h00};
    pv[12] = '{10'd330, 10'd431, 1'b1, 6'h00};
    pv[13] = '{10'd364, 10'd448, 1'b1, 6'h00};

    // 1: reset asserted from time 0, sampled mid-line
    model_reset();
    spawn_lane = 3'd2; valid = 1'b1; col = 10'd300; row = 10'd200;
    #12;
    check("rst_rgb", 32'(rgb), 32'h0);
    check("rst_score", 32'(score), 32'h0);
    check("rst_ready", 32'(spawn_ready), 32'h0);
    $display("reset: rgb=%h score=%h ready=%b", rgb, score, spawn_ready);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_cycle();
    #1;
    check("ready_after_rst", 32'(spawn_ready), 32'h1);
    $display("release: ready(lane2)=%b", spawn_ready);

    // static pixel table on an empty field, offset 0
    for (int i = 0; i < 14; i++) begin
      col = pv[i].c; row = pv[i].r; valid = pv[i].v;
      do_cycle();
      check("pix_tbl", 32'(rgb), 32'(pv[i].exp));
      $display("pix col=%0d row=%0d valid=%b rgb=%h exp=%h", pv[i].c, pv[i].r, pv[i].v, rgb, pv[i].exp);
    end

    // 2: spawn lane 0, scroll to hit slot, hit it
    col = 10'd230; row = 10'd433; valid = 1'b1;
    spawn_valid = 1'b1; spawn_lane = 3'd0; do_cycle(); spawn_valid = 1'b0;
    ticks(224);
    do_cycle();
    check("A_note_px", 32'(rgb), 32'h0C);
    btn = 5'b00001; do_cycle();
    check("A_hit", 32'(hit), 32'h01);
    do_cycle();
    check("A_score", 32'(score), 32'h00001);
    check("A_hit_once", 32'(hit), 32'h0);
    check("A_px_gone", 32'(rgb), 32'h00);
    btn = '0; do_cycle();
    $display("seqA: hit lane0 score=%h", score);

    // 3: empty press, then hold
    btn = 5'b01000; do_cycle();
    check("B_miss", 32'(miss), 32'h08);
    do_cycle();
    check("B_no_repeat", 32'(miss), 32'h0);
    check("B_score", 32'(score), 32'h00001);
    btn = '0; do_cycle();
    $display("seqB: empty press lane3 -> miss, score=%h", score);

    // 4: fall-off and spawn while pending
    spawn_valid = 1'b1; spawn_lane = 3'd1; do_cycle();
    #1;
    check("C_ready_pending", 32'(spawn_ready), 32'h0);
    do_cycle(); spawn_valid = 1'b0;
    ticks(247);
    frame_tick = 1'b1; do_cycle(); frame_tick = 1'b0;
    check("C_falloff", 32'(miss), 32'h02);
    $display("seqC: lane1 note fell off, miss=%b", miss);

    // 5-lane simultaneous hit
    for (int l = 0; l < NL; l++) begin
      spawn_valid = 1'b1; spawn_lane = 3'(l); do_cycle();
    end
    spawn_valid = 1'b0;
    ticks(224);
    btn = 5'h1F; do_cycle();
    check("F_hit_all", 32'(hit), 32'h1F);
    do_cycle();
    check("F_score", 32'(score), 32'h00006);
    btn = '0; do_cycle();
    $display("seqF: 5-lane hit score=%h", score);

    // 5: press coincident with SHIFT
    spawn_valid = 1'b1; spawn_lane = 3'd2; do_cycle(); spawn_valid = 1'b0;
    ticks(224);
    ticks(7);
    frame_tick = 1'b1; btn = 5'b00100; do_cycle(); frame_tick = 1'b0;
    check("D_hit_on_shift", 32'(hit), 32'h04);
    col = 10'd340; row = 10'd450; do_cycle();
    check("D_slot28_empty", 32'(rgb), 32'h00);
    check("D_score", 32'(score), 32'h00007);
    btn = '0; do_cycle();
    $display("seqD: hit on shift, score=%h", score);

    // 6: clear overrides spawn and press
    spawn_valid = 1'b1; spawn_lane = 3'd4; do_cycle();
    clear = 1'b1; spawn_lane = 3'd3; btn = 5'b00001; do_cycle();
    check("E_no_hit", 32'(hit), 32'h0);
    check("E_no_miss", 32'(miss), 32'h0);
    clear = 1'b0; spawn_valid = 1'b0; spawn_lane = 3'd4;
    do_cycle();
    check("E_score", 32'(score), 32'h0);
    spawn_lane = 3'd3; #1;
    check("E_lane3_ready", 32'(spawn_ready), 32'h1);
    btn = '0; do_cycle();
    $display("seqE: clear -> score=%h", score);

    // randomized play against the model
    for (int i = 0; i < 4000; i++) begin
      frame_tick  = 1'($urandom % 2);
      spawn_valid = ($urandom % 4) == 0;
      spawn_lane  = 3'($urandom % 8);
      clear       = ($urandom % 500) == 0;
      valid       = ($urandom % 8) != 0;
      for (int l = 0; l < NL; l++) if (($urandom % 6) == 0) btn[l] = ~btn[l];
      if ($urandom % 2) col = 10'(220 + ($urandom % 5) * 55 + $urandom_range(0, 39));
      else              col = 10'($urandom % 640);
      row = 10'($urandom % 480);
      do_cycle();
    end
    $display("random: 4000 cycles, score=%h", score);

    // reset mid-frame with live state
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rgb", 32'(rgb), 32'h0);
    check("mid_rst_score", 32'(score), 32'h0);
    check("mid_rst_ready", 32'(spawn_ready), 32'h0);
    frame_tick = 1'b0; spawn_valid = 1'b0; clear = 1'b0; btn = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 300; i++) begin
      frame_tick  = 1'($urandom % 2);
      spawn_valid = ($urandom % 3) == 0;
      spawn_lane  = 3'($urandom % 6);
      for (int l = 0; l < NL; l++) if (($urandom % 5) == 0) btn[l] = ~btn[l];
      col = 10'($urandom % 640); row = 10'($urandom % 480); valid = 1'b1;
      do_cycle();
    end
    $display("post-reset random: 300 cycles");

    // score accumulator: random adds, then saturation
    acc_clear = 1'b1; @(posedge clk); #1; acc_clear = 1'b0;
    check("acc_clear", 32'(acc_score), 32'h0);
    a_model = 0;
    for (int i = 0; i < 2000; i++) begin
      acc_add = 4'($urandom_range(0, 8));
      a_model = a_model + int'(acc_add);
      @(posedge clk); #1;
      check("acc_rand", 32'(acc_score), 32'(to_bcd(a_model)));
    end
    $display("acc random: score=%h", acc_score);
    acc_add = '0; acc_clear = 1'b1; @(posedge clk); #1; acc_clear = 1'b0;
    check("acc_clear2", 32'(acc_score), 32'h0);
    acc_add = 4'd8;
    repeat (12499) @(posedge clk);
    #1;
    check("acc_99992", 32'(acc_score), 32'h99992);
    acc_add = 4'd6; @(posedge clk); #1;
    check("acc_99998", 32'(acc_score), 32'h99998);
    acc_add = 4'd5; @(posedge clk); #1;
    check("acc_sat", 32'(acc_score), 32'h99999);
    acc_add = 4'd8; @(posedge clk); #1;
    check("acc_sat_hold", 32'(acc_score), 32'h99999);
    acc_add = '0;
    $display("acc saturation: score=%h", acc_score);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
